// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Request handshake between a reset initiator and reset_sequencer.
//   req_valid : initiator -> sequencer, asks for a full reset sequence
//   req_ready : sequencer -> initiator, high only while the sequencer is idle
interface reset_sequencer_if;
  logic req_valid;
  logic req_ready;

  modport master (output req_valid, input  req_ready);
  modport slave  (input  req_valid, output req_ready);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Generates ordered active-low resets for downstream domains. On reset
//   release or an accepted request, all outputs are held low for at least
//   ASSERT_CYCLES, then released one by one in index order. Each release
//   waits for that domain's synchronized feedback before the next stage.
//   Any feedback wait longer than ACK_TIMEOUT sets a sticky error and the
//   sequence carries on.
// Ports:
//   clock       : single rising-edge clock
//   reset       : synchronous, active-high
//   req         : request handshake (slave side)
//   out_reset_n : registered active-low resets, one per domain
//   fb_reset_n  : per-domain reset feedback, asynchronous, double-flopped here
//   busy        : high in every state except idle
//   done        : one-cycle pulse at the end of a sequence
//   timeout_err : sticky feedback-timeout flag
//   err_clear   : clears timeout_err (a same-cycle timeout takes priority)
module reset_sequencer #(
  parameter int unsigned NUM_OUT       = 3,
  parameter int unsigned ASSERT_CYCLES = 16,
  parameter int unsigned STAGE_GAP     = 4,
  parameter int unsigned ACK_TIMEOUT   = 256
) (
  input  logic               clock,
  input  logic               reset,
  reset_sequencer_if.slave   req,
  output logic [NUM_OUT-1:0] out_reset_n,
  input  logic [NUM_OUT-1:0] fb_reset_n,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  input  logic               err_clear
);

  localparam int unsigned MAX_AG  = (ASSERT_CYCLES > STAGE_GAP) ? ASSERT_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_CNT = (MAX_AG > ACK_TIMEOUT) ? MAX_AG : ACK_TIMEOUT;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam int unsigned IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_LOW,
    S_REL,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [NUM_OUT-1:0] fb_meta;
  logic [NUM_OUT-1:0] fb_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      fb_meta       <= '0;
      fb_sync       <= '0;
      state         <= S_ASSERT;
      cnt           <= '0;
      idx           <= '0;
      out_reset_n   <= '0;
      req.req_ready <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      fb_meta <= fb_reset_n;
      fb_sync <= fb_meta;
      done    <= 1'b0;

      // Clear first so a timeout assignment below in the same cycle wins.
      if (err_clear) begin
        timeout_err <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (req.req_valid && req.req_ready) begin
            state         <= S_ASSERT;
            cnt           <= '0;
            idx           <= '0;
            out_reset_n   <= '0;
            req.req_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end

        S_ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            state <= S_WAIT_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_WAIT_LOW: begin
          if ((fb_sync == '0) || (cnt == ACK_LAST)) begin
            if (fb_sync != '0) begin
              timeout_err <= 1'b1;
            end
            state            <= S_REL;
            cnt              <= '0;
            out_reset_n[idx] <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_REL: begin
          if (fb_sync[idx] || (cnt == ACK_LAST)) begin
            if (!fb_sync[idx]) begin
              timeout_err <= 1'b1;
            end
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state                     <= S_REL;
            cnt                       <= '0;
            idx                       <= idx + IW'(1);
            out_reset_n[idx + IW'(1)] <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          out_reset_n   <= '1;
          req.req_ready <= 1'b1;
          busy          <= 1'b0;
        end

        default: begin
          state       <= S_ASSERT;
          cnt         <= '0;
          idx         <= '0;
          out_reset_n <= '0;
          busy        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Single-clock reset controller that generates and orders the active-low reset outputs consumed by the design's per-domain reset synchronizers. It accepts a reset request over a valid/ready handshake and holds all outputs low for a minimum interval. It then releases them one at a time in index order, waiting for each downstream domain's synchronized reset feedback before releasing the next. It sits at the top of the shell-to-CL reset tree, upstream of every domain-local synchronizer.

## Interface
- NUM_OUT, 3, number of downstream reset outputs (1..8)
- ASSERT_CYCLES, 16, minimum cycles all outputs are held low (≥2)
- STAGE_GAP, 4, cycles between feedback-high on stage i and release of stage i+1 (≥1)
- ACK_TIMEOUT, 256, cycles to wait for any feedback transition before flagging an error (≥4)

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request a full reset sequence
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- out_reset_n  out  NUM_OUT  active-low resets to downstream domains, registered
- fb_reset_n  in  NUM_OUT  synchronized reset_n returned by each downstream domain; asynchronous to clock, double-flopped internally (sync flops reset to 0)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes
- timeout_err  out  1  sticky; set on any feedback timeout
- err_clear  in  1  clears timeout_err

## Operation
- Reset values: out_reset_n = all 0, req_ready = 0, busy = 1, done = 0, timeout_err = 0, state = ASSERT, counters = 0, stage index = 0. Deasserting reset therefore starts a sequence automatically, with no request needed.
- States:
  - IDLE: req_ready = 1, all outputs 1. Accepted request → ASSERT.
  - ASSERT: all out_reset_n = 0; count ASSERT_CYCLES → WAIT_LOW.
  - WAIT_LOW: wait until all fb_sync == 0 → REL.
  - REL: out_reset_n[i] = 1; wait fb_sync[i] == 1 → GAP. If i == NUM_OUT-1, go to DONE instead.
  - GAP: count STAGE_GAP, then i++ → REL.
  - DONE: done = 1 for one cycle → IDLE.
- Released stages stay at 1 until the next ASSERT. Unreleased stages stay at 0.
- Timeout: in WAIT_LOW and REL, a single counter runs from state entry. Reaching ACK_TIMEOUT sets timeout_err and advances as if the feedback had arrived. The sequence never deadlocks.
- err_clear clears timeout_err the next cycle. A new timeout in the same cycle wins (stays set).
- req_valid while busy is ignored (req_ready = 0). It is not queued.
- reset mid-sequence: all outputs return to their reset values the next cycle and the sequence restarts from ASSERT. timeout_err is cleared.
- Counter widths: $clog2(max(ASSERT_CYCLES, STAGE_GAP, ACK_TIMEOUT)+1). Counters do not wrap; each is cleared on state entry.

## Timing
- Request accepted at edge a: at a+1, out_reset_n = 0, busy = 1, req_ready = 0.
- Outputs are low for at least ASSERT_CYCLES cycles, plus the WAIT_LOW time.
- The fb_sync path is 2 cycles: a feedback change is visible to the FSM 2 edges after it occurs at the pin.
- If fb_sync[i] is first seen high at edge t, out_reset_n[i+1] rises at t+STAGE_GAP+1.
- done pulses at the edge after the last stage's feedback is seen. req_ready = 1 the following cycle.
- All outputs are glitch-free registers. out_reset_n changes only on state transitions.

## Test plan
- Power-on: NUM_OUT=3, fb_reset_n tied directly to out_reset_n; deassert reset at cycle 0.
  - out_reset_n = 3'b000 for ≥16 cycles.
  - Then 001, 011, 111, with bit i+1 rising STAGE_GAP+3 = 7 cycles after bit i.
  - done pulses once, timeout_err = 0.
- Request handshake: in IDLE, pulse req_valid for 1 cycle.
  - out_reset_n = 000 on the next cycle and busy = 1.
  - A second req_valid during the sequence is ignored: exactly one done pulse.
- Stuck feedback: fb_reset_n[1] held at 0.
  - Stage 1 is released, then after 256 cycles timeout_err = 1.
  - Stage 2 releases 4 cycles later and done still pulses.
  - err_clear then clears timeout_err.
- Stuck-high feedback: fb_reset_n[0] held at 1 during ASSERT.
  - WAIT_LOW times out after 256 cycles, timeout_err = 1, and release proceeds.
- Reset mid-sequence: assert reset while out_reset_n = 011.
  - The next cycle shows 000, busy = 1, timeout_err = 0.
  - A full sequence then repeats after deassert.
- Simultaneous err_clear and timeout in the same cycle: timeout_err remains 1.
